// File: rtl/vga_compositor.sv
// vga_compositor: final video stage. Priority-merges the mole, title,
// game-over and text layers over a background colour, scales the result by
// a fade level and emits 4-bit RGB with sync delayed to match the pixel
// pipeline. Define VGA_COMPOSITOR_FADE_EN to build the frame-based
// fade-out/fade-in sequencer; without it screen changes are immediate.
module vga_compositor #(
  parameter int          PIPE_DELAY       = 3,
  parameter int          FADE_STEP_FRAMES = 2,
  parameter logic [23:0] BG_COLOR         = 24'h00_80_00
) (
  input  logic        vclock,
  input  logic        reset,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        blank_in,
  input  logic [1:0]  screen_sel,
  input  logic [23:0] mole_pixel,
  input  logic [23:0] title_pixel,
  input  logic [23:0] gameover_pixel,
  input  logic [23:0] text_pixel,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        fade_busy
);

  localparam logic [11:0] BG_RGB = {BG_COLOR[23:20], BG_COLOR[15:12], BG_COLOR[7:4]};

  logic [PIPE_DELAY-1:0] hs_pipe;
  logic [PIPE_DELAY-1:0] vs_pipe;
  logic [PIPE_DELAY-1:0] blank_pipe;
  logic                  vsync_prev;
  logic                  frame_tick;
  logic [1:0]            active_screen;
  logic [3:0]            level;
  logic [11:0]           layer_rgb;
  logic [11:0]           mole_rgb;
  logic [11:0]           title_rgb;
  logic [11:0]           gameover_rgb;
  logic [11:0]           text_rgb;

  assign mole_rgb     = {mole_pixel[23:20], mole_pixel[15:12], mole_pixel[7:4]};
  assign title_rgb    = {title_pixel[23:20], title_pixel[15:12], title_pixel[7:4]};
  assign gameover_rgb = {gameover_pixel[23:20], gameover_pixel[15:12], gameover_pixel[7:4]};
  assign text_rgb     = {text_pixel[23:20], text_pixel[15:12], text_pixel[7:4]};

  // Brightness scaling: (c * (level+1)) >> 4, so level 15 is identity.
  function automatic logic [3:0] scale(input logic [3:0] c, input logic [3:0] lvl);
    logic [7:0] prod;
    prod = {4'd0, c} * ({4'd0, lvl} + 8'd1);
    return 4'(prod >> 4);
  endfunction

  // Delay sync and blank so they line up with the ROM-pipelined layers.
  always_ff @(posedge vclock or posedge reset) begin
    if (reset) begin
      hs_pipe    <= '1;
      vs_pipe    <= '1;
      blank_pipe <= '1;
    end else begin
      hs_pipe[0]    <= hsync_in;
      vs_pipe[0]    <= vsync_in;
      blank_pipe[0] <= blank_in;
      for (int i = 1; i < PIPE_DELAY; i++) begin
        hs_pipe[i]    <= hs_pipe[i-1];
        vs_pipe[i]    <= vs_pipe[i-1];
        blank_pipe[i] <= blank_pipe[i-1];
      end
    end
  end

  // Remember last vsync so its falling edge marks the start of a new frame.
  always_ff @(posedge vclock or posedge reset) begin
    if (reset) vsync_prev <= 1'b1;
    else       vsync_prev <= vsync_in;
  end

  assign frame_tick = vsync_prev & ~vsync_in;

  // Pick the topmost non-transparent layer for the active screen.
  always_comb begin
    layer_rgb = BG_RGB;
    case (active_screen)
      2'd0: begin
        if (text_pixel != 24'h0)       layer_rgb = text_rgb;
        else if (title_pixel != 24'h0) layer_rgb = title_rgb;
      end
      2'd1: begin
        if (text_pixel != 24'h0)      layer_rgb = text_rgb;
        else if (mole_pixel != 24'h0) layer_rgb = mole_rgb;
      end
      2'd2: begin
        if (text_pixel != 24'h0)          layer_rgb = text_rgb;
        else if (gameover_pixel != 24'h0) layer_rgb = gameover_rgb;
      end
      default: layer_rgb = BG_RGB;
    endcase
    if (blank_pipe[PIPE_DELAY-1]) layer_rgb = 12'h000;
  end

  // Output register: scaled colour and the final sync stage together.
  always_ff @(posedge vclock or posedge reset) begin
    if (reset) begin
      vga_r  <= 4'h0;
      vga_g  <= 4'h0;
      vga_b  <= 4'h0;
      vga_hs <= 1'b1;
      vga_vs <= 1'b1;
    end else begin
      vga_r  <= scale(layer_rgb[11:8], level);
      vga_g  <= scale(layer_rgb[7:4], level);
      vga_b  <= scale(layer_rgb[3:0], level);
      vga_hs <= hs_pipe[PIPE_DELAY-1];
      vga_vs <= vs_pipe[PIPE_DELAY-1];
    end
  end

`ifdef VGA_COMPOSITOR_FADE_EN
  typedef enum logic [1:0] {IDLE, FADE_OUT, SWAP, FADE_IN} fade_state_t;

  localparam logic [7:0] STEP_LAST = 8'(FADE_STEP_FRAMES - 1);

  fade_state_t state;
  fade_state_t state_next;
  logic [7:0]  step_cnt;
  logic [7:0]  step_cnt_next;
  logic [3:0]  level_next;
  logic [1:0]  active_next;
  logic        step;

  assign step      = frame_tick && (step_cnt == STEP_LAST);
  assign fade_busy = (state != IDLE);

  // Fade sequencer registers; only move on ticks or SWAP, i.e. in vblank.
  always_ff @(posedge vclock or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      level         <= 4'd15;
      step_cnt      <= 8'd0;
      active_screen <= 2'd0;
    end else begin
      state         <= state_next;
      level         <= level_next;
      step_cnt      <= step_cnt_next;
      active_screen <= active_next;
    end
  end

  // Next-state logic: dim to black, swap screens, brighten back up.
  always_comb begin
    state_next    = state;
    level_next    = level;
    step_cnt_next = step_cnt;
    active_next   = active_screen;
    case (state)
      IDLE: begin
        level_next    = 4'd15;
        step_cnt_next = 8'd0;
        if (frame_tick && (screen_sel != active_screen)) state_next = FADE_OUT;
      end
      FADE_OUT: begin
        if (step) begin
          step_cnt_next = 8'd0;
          level_next    = level - 4'd1;
          if (level == 4'd1) state_next = SWAP;
        end else if (frame_tick) begin
          step_cnt_next = step_cnt + 8'd1;
        end
      end
      SWAP: begin
        active_next   = screen_sel;
        step_cnt_next = 8'd0;
        state_next    = FADE_IN;
      end
      FADE_IN: begin
        if (step) begin
          step_cnt_next = 8'd0;
          level_next    = level + 4'd1;
          if (level == 4'd14) state_next = IDLE;
        end else if (frame_tick) begin
          step_cnt_next = step_cnt + 8'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end
`else
  assign level     = 4'd15;
  assign fade_busy = 1'b0;

  // Without fading, adopt the requested screen at each frame start.
  always_ff @(posedge vclock or posedge reset) begin
    if (reset)           active_screen <= 2'd0;
    else if (frame_tick) active_screen <= screen_sel;
  end
`endif

endmodule
